// File: rtl/tty_writer_pkg.sv
// Shared definitions for the tty_writer text-RAM writer: FSM states,
// control-code byte values and text-RAM address field geometry.
package tty_writer_pkg;

  // Writer FSM states. IDLE is the only state that accepts host bytes.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CLR_LINE = 2'd1,
    ST_CLR_ALL  = 2'd2
  } tty_state_t;

  // Control codes interpreted by the writer.
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TILDE = 8'h7E;

  // Text-RAM address fields: {row, col}. Fixed at the maximum geometry.
  localparam int ROW_W  = 6;
  localparam int COL_W  = 7;
  localparam int ADDR_W = ROW_W + COL_W;

  // Printable ASCII range, space through tilde inclusive.
  function automatic logic is_printable(input logic [7:0] b);
    return (b >= CH_SPACE) && (b <= CH_TILDE);
  endfunction

  // Pack a row/column pair into a text-RAM address.
  function automatic logic [ADDR_W-1:0] make_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/tty_writer.sv
// Character-stream to text-RAM writer. Printable bytes are written at the
// cursor, CR/LF/BS/FF move the cursor, and scrolling past the last row or an
// FF triggers a space-fill of one line or the whole buffer, during which the
// host stream is stalled through ch_ready.
//
// Host handshake: a byte transfers on a rising clk_data edge where both
// ch_valid and ch_ready are high. ch_ready depends only on internal state,
// never on ch_valid; the host may hold ch_valid high across stalls and must
// keep ch_data stable until the transfer edge.
module tty_writer
  import tty_writer_pkg::*;
#(
  parameter int NCOLS = 128,
  parameter int NROWS = 64
) (
  input  logic               clk_data,
  input  logic               irstn,
  input  logic [7:0]         ch_data,
  input  logic               ch_valid,
  output logic               ch_ready,
  output logic [ADDR_W-1:0]  addrb,
  output logic [7:0]         dinb,
  output logic               web,
  output logic               enb,
  output logic [ROW_W-1:0]   cur_row,
  output logic [COL_W-1:0]   cur_col,
  output logic               busy,
  output tty_state_t         fsm_state
);

  // Geometry derived from the parameters. Column bits below COL_W and row
  // bits below ROW_W are the only ones ever non-zero.
  localparam int COL_BITS = $clog2(NCOLS);

  localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(NCOLS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(NROWS - 1);
  localparam logic [ADDR_W-1:0] COL_MASK   = ADDR_W'(NCOLS - 1);
  localparam logic [ADDR_W-1:0] ROW_MASK   = ADDR_W'(NROWS - 1);
  localparam logic [ADDR_W-1:0] LINE_LAST  = ADDR_W'(NCOLS - 1);
  localparam logic [ADDR_W-1:0] ALL_LAST   = ADDR_W'(NROWS * NCOLS - 1);

  tty_state_t        state;
  logic              alive;
  logic [ADDR_W-1:0] clr_cnt;

  // Decoded view of the byte offered this cycle.
  logic              accept;
  logic              printable;
  logic              do_wrap;
  logic              do_lf;
  logic [COL_W-1:0]  clr_all_col;
  logic [ROW_W-1:0]  clr_all_row;

  // Decode the incoming byte and split the shared clear counter into fields.
  always_comb begin
    accept      = ch_valid && ch_ready;
    printable   = is_printable(ch_data);
    do_wrap     = accept && printable && (cur_col == COL_LAST);
    do_lf       = do_wrap || (accept && (ch_data == CH_LF));
    clr_all_col = COL_W'(clr_cnt & COL_MASK);
    clr_all_row = ROW_W'((clr_cnt >> COL_BITS) & ROW_MASK);
  end

  // ch_ready stays low until the first edge after reset release.
  always_ff @(posedge clk_data or negedge irstn) begin
    if (!irstn) begin
      alive <= 1'b0;
    end else begin
      alive <= 1'b1;
    end
  end

  // Writer FSM with registered RAM outputs and cursor.
  always_ff @(posedge clk_data or negedge irstn) begin
    if (!irstn) begin
      state   <= ST_IDLE;
      cur_row <= '0;
      cur_col <= '0;
      clr_cnt <= '0;
      web     <= 1'b0;
      addrb   <= '0;
      dinb    <= '0;
    end else begin
      web <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (printable) begin
              web   <= 1'b1;
              addrb <= make_addr(cur_row, cur_col);
              dinb  <= ch_data;
              if (cur_col == COL_LAST) begin
                cur_col <= '0;
              end else begin
                cur_col <= cur_col + 1'b1;
              end
            end else begin
              case (ch_data)
                CH_CR: cur_col <= '0;
                CH_BS: begin
                  if (cur_col != '0) begin
                    cur_col <= cur_col - 1'b1;
                  end
                end
                CH_FF: begin
                  cur_row <= '0;
                  cur_col <= '0;
                  clr_cnt <= '0;
                  state   <= ST_CLR_ALL;
                end
                default: ;
              endcase
            end
            // Line feed, explicit or from auto-wrap; the last row scrolls
            // back to row 0 and blanks it.
            if (do_lf) begin
              if (cur_row == ROW_LAST) begin
                cur_row <= '0;
                clr_cnt <= '0;
                state   <= ST_CLR_LINE;
              end else begin
                cur_row <= cur_row + 1'b1;
              end
            end
          end
        end

        ST_CLR_LINE: begin
          web   <= 1'b1;
          addrb <= make_addr(cur_row, COL_W'(clr_cnt & COL_MASK));
          dinb  <= CH_SPACE;
          if (clr_cnt == LINE_LAST) begin
            state <= ST_IDLE;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end

        ST_CLR_ALL: begin
          web   <= 1'b1;
          addrb <= make_addr(clr_all_row, clr_all_col);
          dinb  <= CH_SPACE;
          if (clr_cnt == ALL_LAST) begin
            state <= ST_IDLE;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // Status outputs derived from the registered state.
  always_comb begin
    ch_ready  = alive && (state == ST_IDLE);
    busy      = (state != ST_IDLE);
    enb       = web;
    fsm_state = state;
  end

  // The RAM enable always tracks the write strobe.
  always @(posedge clk_data) begin
    if (irstn) begin
      assert (enb == web) else $error("enb differs from web");
    end
  end

endmodule

// File: tb/tb_tty_writer.sv
// Directed bench for tty_writer: reset, printable writes, control codes,
// auto-wrap, line/full clears and reset during a full clear.
module tb_tty_writer;
  import tty_writer_pkg::*;

  logic        clk_data;
  logic        irstn;
  logic [7:0]  ch_data;
  logic        ch_valid;
  logic        ch_ready;
  logic [12:0] addrb;
  logic [7:0]  dinb;
  logic        web;
  logic        enb;
  logic [5:0]  cur_row;
  logic [6:0]  cur_col;
  logic        busy;
  tty_state_t  fsm_state;

  int n_tests;
  int n_fail;
  int cyc;

  logic [12:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  int          wr_cyc_q[$];

  tty_writer #(.NCOLS(128), .NROWS(64)) dut (
    .clk_data (clk_data),
    .irstn    (irstn),
    .ch_data  (ch_data),
    .ch_valid (ch_valid),
    .ch_ready (ch_ready),
    .addrb    (addrb),
    .dinb     (dinb),
    .web      (web),
    .enb      (enb),
    .cur_row  (cur_row),
    .cur_col  (cur_col),
    .busy     (busy),
    .fsm_state(fsm_state)
  );

  // Clock and cycle counter.
  initial clk_data = 1'b0;
  always #5 clk_data = ~clk_data;
  always @(posedge clk_data) cyc <= cyc + 1;

  // Write log sampled on the falling edge.
  always @(negedge clk_data) begin
    if (web === 1'b1) begin
      wr_addr_q.push_back(addrb);
      wr_data_q.push_back(dinb);
      wr_cyc_q.push_back(cyc);
    end
  end

  task automatic step();
    @(negedge clk_data);
    #1;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
  endtask

  task automatic do_reset();
    irstn    = 1'b0;
    ch_valid = 1'b0;
    step();
    step();
    irstn = 1'b1;
    step();
    clear_log();
  endtask

  // Offer one byte and wait (bounded) for its transfer edge.
  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    bit   ok;
    ch_data  = b;
    ch_valid = 1'b1;
    ok       = 0;
    for (int i = 0; i < 20000; i++) begin
      rdy = ch_ready;
      step();
      if (rdy) begin
        ok = 1;
        break;
      end
    end
    ch_valid = 1'b0;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_timeout: byte %h not accepted, required acceptance", b);
    end
  endtask

  task automatic test_reset();
    logic [39:0] outs;
    irstn    = 1'b0;
    ch_valid = 1'b1;
    ch_data  = 8'h41;
    step();
    step();
    outs = {ch_ready, web, enb, addrb, dinb, cur_row, cur_col, busy};
    n_tests++;
    if (outs !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", outs);
    end
    ch_valid = 1'b0;
    irstn    = 1'b1;
    #1;
    n_tests++;
    if (ch_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_before_edge: got %b required 0", ch_ready);
    end
    step();
    n_tests++;
    if (ch_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_after_edge: got %b required 1", ch_ready);
    end
    clear_log();
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_byte(8'h41);
    send_byte(8'h42);
    step();
    n_tests++;
    if (wr_addr_q.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_write_count: got %0d required 2", wr_addr_q.size());
    end else begin
      n_tests++;
      if (wr_addr_q[0] !== 13'h0000 || wr_data_q[0] !== 8'h41) begin
        n_fail++;
        $display("FAIL b2b_first: got %h/%h required 0000/41", wr_addr_q[0], wr_data_q[0]);
      end
      n_tests++;
      if (wr_addr_q[1] !== 13'h0001 || wr_data_q[1] !== 8'h42) begin
        n_fail++;
        $display("FAIL b2b_second: got %h/%h required 0001/42", wr_addr_q[1], wr_data_q[1]);
      end
      n_tests++;
      if (wr_cyc_q[1] - wr_cyc_q[0] != 1) begin
        n_fail++;
        $display("FAIL b2b_spacing: got %0d required 1", wr_cyc_q[1] - wr_cyc_q[0]);
      end
    end
    n_tests++;
    if (cur_col !== 7'd2 || cur_row !== 6'd0) begin
      n_fail++;
      $display("FAIL b2b_cursor: got (%0d,%0d) required (0,2)", cur_row, cur_col);
    end
  endtask

  task automatic test_control_codes();
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(CH_LF);
    for (int i = 0; i < 10; i++) send_byte(8'h78);
    n_tests++;
    if (cur_row !== 6'd5 || cur_col !== 7'd10) begin
      n_fail++;
      $display("FAIL ctrl_setup: got (%0d,%0d) required (5,10)", cur_row, cur_col);
    end
    clear_log();
    send_byte(CH_CR);
    send_byte(CH_LF);
    send_byte(CH_BS);
    step();
    n_tests++;
    if (cur_row !== 6'd6 || cur_col !== 7'd0) begin
      n_fail++;
      $display("FAIL ctrl_cursor: got (%0d,%0d) required (6,0)", cur_row, cur_col);
    end
    n_tests++;
    if (wr_addr_q.size() != 0) begin
      n_fail++;
      $display("FAIL ctrl_no_write: got %0d writes required 0", wr_addr_q.size());
    end
    // Backspace from a non-zero column.
    for (int i = 0; i < 3; i++) send_byte(8'h79);
    send_byte(CH_BS);
    step();
    n_tests++;
    if (cur_col !== 7'd2 || wr_addr_q.size() != 3) begin
      n_fail++;
      $display("FAIL ctrl_bs: got col %0d writes %0d required col 2 writes 3", cur_col, wr_addr_q.size());
    end
  endtask

  task automatic test_discard();
    logic [5:0] r0;
    logic [6:0] c0;
    r0 = cur_row;
    c0 = cur_col;
    clear_log();
    send_byte(8'h07);
    send_byte(8'hC1);
    send_byte(8'h7F);
    step();
    n_tests++;
    if (cur_row !== r0 || cur_col !== c0 || wr_addr_q.size() != 0) begin
      n_fail++;
      $display("FAIL discard: got (%0d,%0d) writes %0d required (%0d,%0d) writes 0",
               cur_row, cur_col, wr_addr_q.size(), r0, c0);
    end
  endtask

  task automatic test_autowrap();
    do_reset();
    for (int i = 0; i < 128; i++) send_byte(8'h62);
    step();
    n_tests++;
    if (cur_row !== 6'd1 || cur_col !== 7'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL autowrap_cursor: got (%0d,%0d) busy %b required (1,0) busy 0", cur_row, cur_col, busy);
    end
    n_tests++;
    if (wr_addr_q.size() != 128 || wr_addr_q[127] !== 13'h007F) begin
      n_fail++;
      $display("FAIL autowrap_last_write: got %0d writes required 128 ending at 007f", wr_addr_q.size());
    end
  endtask

  task automatic test_clear_line();
    int low_cnt;
    int ready_cyc;
    int bad;
    do_reset();
    for (int i = 0; i < 63; i++) send_byte(CH_LF);
    for (int i = 0; i < 127; i++) send_byte(8'h61);
    n_tests++;
    if (cur_row !== 6'd63 || cur_col !== 7'd127) begin
      n_fail++;
      $display("FAIL cline_setup: got (%0d,%0d) required (63,127)", cur_row, cur_col);
    end
    clear_log();
    send_byte(8'h5A);
    n_tests++;
    if (fsm_state !== ST_CLR_LINE || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL cline_state: got %0d busy %b required %0d busy 1", fsm_state, busy, ST_CLR_LINE);
    end
    low_cnt   = 0;
    ready_cyc = -1;
    for (int i = 0; i < 1000; i++) begin
      if (ch_ready === 1'b1) begin
        ready_cyc = cyc;
        break;
      end
      low_cnt++;
      step();
    end
    step();
    n_tests++;
    if (low_cnt != 128) begin
      n_fail++;
      $display("FAIL cline_ready_low: got %0d cycles required 128", low_cnt);
    end
    n_tests++;
    if (wr_addr_q.size() != 129) begin
      n_fail++;
      $display("FAIL cline_write_count: got %0d required 129", wr_addr_q.size());
    end else begin
      n_tests++;
      if (wr_addr_q[0] !== 13'h1FFF || wr_data_q[0] !== 8'h5A) begin
        n_fail++;
        $display("FAIL cline_char: got %h/%h required 1fff/5a", wr_addr_q[0], wr_data_q[0]);
      end
      bad = 0;
      for (int i = 0; i < 128; i++) begin
        if (wr_addr_q[i+1] !== 13'(i) || wr_data_q[i+1] !== 8'h20 ||
            wr_cyc_q[i+1] != wr_cyc_q[0] + 1 + i) bad++;
      end
      n_tests++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL cline_fill: got %0d bad writes required 0", bad);
      end
      n_tests++;
      if (wr_cyc_q[128] != ready_cyc) begin
        n_fail++;
        $display("FAIL cline_last_write_cycle: got %0d required %0d", wr_cyc_q[128], ready_cyc);
      end
    end
    n_tests++;
    if (cur_row !== 6'd0 || cur_col !== 7'd0) begin
      n_fail++;
      $display("FAIL cline_cursor: got (%0d,%0d) required (0,0)", cur_row, cur_col);
    end
  endtask

  task automatic test_clear_all();
    int busy_cnt;
    int idle_cyc;
    int bad;
    send_byte(8'h71);
    send_byte(CH_LF);
    clear_log();
    send_byte(CH_FF);
    n_tests++;
    if (fsm_state !== ST_CLR_ALL || cur_row !== 6'd0 || cur_col !== 7'd0) begin
      n_fail++;
      $display("FAIL call_entry: got state %0d (%0d,%0d) required %0d (0,0)",
               fsm_state, cur_row, cur_col, ST_CLR_ALL);
    end
    busy_cnt = 0;
    idle_cyc = -1;
    for (int i = 0; i < 20000; i++) begin
      if (busy === 1'b0) begin
        idle_cyc = cyc;
        break;
      end
      busy_cnt++;
      step();
    end
    step();
    n_tests++;
    if (busy_cnt != 8192) begin
      n_fail++;
      $display("FAIL call_busy_cycles: got %0d required 8192", busy_cnt);
    end
    n_tests++;
    if (wr_addr_q.size() != 8192) begin
      n_fail++;
      $display("FAIL call_write_count: got %0d required 8192", wr_addr_q.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 8192; i++) begin
        if (wr_addr_q[i] !== 13'(i) || wr_data_q[i] !== 8'h20) bad++;
      end
      n_tests++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL call_fill: got %0d bad writes required 0", bad);
      end
      n_tests++;
      if (wr_cyc_q[8191] != idle_cyc) begin
        n_fail++;
        $display("FAIL call_last_write_cycle: got %0d required %0d", wr_cyc_q[8191], idle_cyc);
      end
    end
    n_tests++;
    if (cur_row !== 6'd0 || cur_col !== 7'd0 || ch_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL call_end: got (%0d,%0d) ready %b required (0,0) ready 1", cur_row, cur_col, ch_ready);
    end
  endtask

  task automatic test_reset_mid_clear();
    logic [38:0] outs;
    bit reached;
    do_reset();
    send_byte(8'h30);
    clear_log();
    send_byte(CH_FF);
    reached = 0;
    for (int i = 0; i < 1000; i++) begin
      if (wr_addr_q.size() == 300) begin
        reached = 1;
        break;
      end
      step();
    end
    n_tests++;
    if (!reached) begin
      n_fail++;
      $display("FAIL midclr_reach: got %0d writes required 300", wr_addr_q.size());
    end
    irstn = 1'b0;
    #1;
    outs = {ch_ready, web, enb, addrb, dinb, cur_row, cur_col};
    n_tests++;
    if (outs !== 39'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midclr_async_zero: got %h busy %b required 0 busy 0", outs, busy);
    end
    step();
    irstn = 1'b1;
    step();
    n_tests++;
    if (ch_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midclr_ready: got %b required 1", ch_ready);
    end
    for (int i = 0; i < 10; i++) step();
    n_tests++;
    if (wr_addr_q.size() != 300 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midclr_no_more_writes: got %0d writes busy %b required 300 busy 0",
               wr_addr_q.size(), busy);
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    cyc      = 0;
    irstn    = 1'b0;
    ch_valid = 1'b0;
    ch_data  = 8'h00;
    test_reset();
    test_back_to_back();
    test_control_codes();
    test_discard();
    test_autowrap();
    test_clear_line();
    test_clear_all();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tty_writer.md
TTY_WRITER -- requirements
Module: tty_writer

Interface
REQ-001 Parameter NCOLS, default 128: character columns per text row, power of two, at most 128.
REQ-002 Parameter NROWS, default 64: text rows in the buffer, power of two, at most 64.
REQ-003 Port clk_data, input, 1 bit: the single clock; every register is clocked on its rising edge.
REQ-004 Port irstn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port ch_data, input, 8 bits: character byte from the host stream.
REQ-006 Port ch_valid, input, 1 bit: ch_data is valid.
REQ-007 Port ch_ready, output, 1 bit: the block accepts a byte at this edge; the transfer is ch_valid & ch_ready at the rising edge.
REQ-008 Port addrb, output, 13 bits: text RAM address {row[5:0], col[6:0]}.
REQ-009 Port dinb, output, 8 bits: byte written to the text RAM.
REQ-010 Port web, output, 1 bit: text RAM write strobe.
REQ-011 Port enb, output, 1 bit: text RAM enable; always equal to web.
REQ-012 Port cur_row, output, 6 bits: current cursor row.
REQ-013 Port cur_col, output, 7 bits: current cursor column.
REQ-014 Port busy, output, 1 bit: high while the block is in a clear state.

Function
REQ-015 States: IDLE, CLR_LINE, CLR_ALL; ch_ready = (state == IDLE).
REQ-016 addrb, dinb and web are registered; each write strobe lasts exactly one cycle.
REQ-017 Printable byte (0x20-0x7E) accepted at edge k: at the cycle after edge k, web = 1, addrb = {cur_row, cur_col} sampled at edge k, and dinb = the byte.
REQ-018 After a printable byte, cur_col increments; back-to-back printables sustain one byte per cycle.
REQ-019 Printable byte at cur_col = NCOLS-1: the byte is written at NCOLS-1, then cur_col becomes 0 and a line feed is applied (auto-wrap).
REQ-020 CR (0x0D): cur_col becomes 0; no write.
REQ-021 BS (0x08): if cur_col > 0 then cur_col decrements; no write; no effect at column 0.
REQ-022 LF (0x0A) or auto-wrap with cur_row < NROWS-1: cur_row increments; no write; state remains IDLE.
REQ-023 LF (0x0A) or auto-wrap with cur_row = NROWS-1: cur_row wraps to 0 and the state becomes CLR_LINE.
REQ-024 In CLR_LINE: NCOLS consecutive cycles write 0x20 to {cur_row, 0..NCOLS-1} in ascending column order, then return to IDLE.
REQ-025 In CLR_LINE, cur_col is unchanged.
REQ-026 FF (0x0C): cursor goes to (0,0); state CLR_ALL writes 0x20 to every address from 0 to NROWS*NCOLS-1 in ascending order, one per cycle, then returns to IDLE.
REQ-027 All other bytes, including 0x7F and 0x80-0xFF, are accepted and discarded with no state change.
REQ-028 busy = (state != IDLE).
REQ-029 In a clear state the next write is issued in the cycle after entry.
REQ-030 The last clear write occurs in the same cycle that ch_ready reasserts.
REQ-031 Address, row and column counters are truncated to their field widths, with no carry into adjacent fields.
REQ-032 Unused upper address bits (when NCOLS < 128 or NROWS < 64) are driven 0.

Reset
REQ-033 While irstn = 0: state = IDLE, cur_row = 0, cur_col = 0, web = 0, enb = 0, addrb = 0, dinb = 0, and ch_ready = 0.
REQ-034 ch_ready rises in the first cycle after irstn deasserts.
REQ-035 Reset asserted mid-clear abandons the clear immediately; there is no further write, and RAM content is left partially cleared.

Structure
REQ-036 Shared package holds: the state enum, the control-code constants (BS, LF, FF, CR, SPACE), and the address field widths (row 6, col 7).
REQ-037 No sub-module is used; a single clear-address counter is shared by CLR_LINE and CLR_ALL.

Verification
REQ-038 Reset, then "AB" back-to-back -> web at addr 0x0000 with 0x41, then at 0x0001 with 0x42, in consecutive cycles; cur_col = 2.
REQ-039 Cursor (5,10) [row, col], send CR, LF, BS -> cursor (6,0), no web pulses.
REQ-040 Cursor (63,127), send 'Z' -> write 0x5A at 0x1FFF; then 128 writes of 0x20 at 0x0000-0x007F; ch_ready low for exactly 128 cycles; cursor (0,0).
REQ-041 Send FF -> 8192 writes of 0x20 covering 0x0000-0x1FFF; busy high for 8192 cycles; cursor (0,0).
REQ-042 irstn pulsed low at write 300 of a CLR_ALL -> outputs zero asynchronously, no further writes, and ch_ready = 1 in the cycle after release.
REQ-043 Send 0x07 and 0xC1 -> both accepted, no writes, cursor unchanged.
